// File: rtl/mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch and the data stage:
// data-side priority, bounded fetch starvation, sub-word store lanes, misalignment and timeout.
module mem_port_arbiter #(
  parameter int MAX_DM_BURST = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ack,
  output logic        if_err,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [1:0]  dm_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ack,
  output logic        dm_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        stall_if,
  output logic        stall_dm
);
  localparam logic [7:0] BURST_MAX = 8'(MAX_DM_BURST);
  localparam logic [7:0] TMO_MAX   = 8'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_DM} state_t;

  state_t      state, state_nx;
  logic [7:0]  tmo_cnt, tmo_nx, tmo_inc;
  logic [7:0]  starve_cnt, starve_nx;
  logic        mem_req_nx, mem_we_nx;
  logic [31:0] mem_addr_nx, mem_wdata_nx;
  logic [3:0]  mem_be_nx;
  logic        if_ack_nx, if_err_nx, dm_ack_nx, dm_err_nx;
  logic [31:0] if_rdata_nx, dm_rdata_nx;
  logic        dm_misaligned, dm_first;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        if_addr_unused;

  // Fetches are always whole words, so the low address bits carry no information.
  assign if_addr_unused = ^if_addr[1:0];

  assign stall_if = if_req & ~if_ack;
  assign stall_dm = dm_req & ~dm_ack;
  assign tmo_inc  = tmo_cnt + 8'd1;

  always_comb begin
    dm_misaligned = (dm_size == 2'b01 && dm_addr[0]) ||
                    (dm_size[1] && dm_addr[1:0] != 2'b00);
    dm_first      = dm_req && (!if_req || starve_cnt < BURST_MAX);
    st_be         = 4'b1111;
    st_wdata      = dm_wdata;
    case (dm_size)
      2'b00: begin
        st_be    = 4'b0001 << dm_addr[1:0];
        st_wdata = {4{dm_wdata[7:0]}};
      end
      2'b01: begin
        st_be    = 4'b0011 << {dm_addr[1], 1'b0};
        st_wdata = {2{dm_wdata[15:0]}};
      end
      default: begin
        st_be    = 4'b1111;
        st_wdata = dm_wdata;
      end
    endcase
  end

  always_comb begin
    state_nx     = state;
    tmo_nx       = tmo_cnt;
    starve_nx    = starve_cnt;
    mem_req_nx   = mem_req;
    mem_we_nx    = mem_we;
    mem_addr_nx  = mem_addr;
    mem_be_nx    = mem_be;
    mem_wdata_nx = mem_wdata;
    if_ack_nx    = 1'b0;
    if_err_nx    = 1'b0;
    dm_ack_nx    = 1'b0;
    dm_err_nx    = 1'b0;
    if_rdata_nx  = if_rdata;
    dm_rdata_nx  = dm_rdata;
    case (state)
      IDLE: begin
        if (dm_first) begin
          // A misaligned access is refused without touching memory or the starvation count.
          if (dm_misaligned) begin
            dm_ack_nx = 1'b1;
            dm_err_nx = 1'b1;
          end else begin
            state_nx     = BUSY_DM;
            tmo_nx       = 8'd0;
            mem_req_nx   = 1'b1;
            mem_we_nx    = dm_we;
            mem_addr_nx  = {dm_addr[31:2], 2'b00};
            mem_be_nx    = dm_we ? st_be : 4'b1111;
            mem_wdata_nx = st_wdata;
            if (if_req)
              starve_nx = (starve_cnt < BURST_MAX) ? starve_cnt + 8'd1 : BURST_MAX;
            else
              starve_nx = 8'd0;
          end
        end else if (if_req) begin
          state_nx     = BUSY_IF;
          tmo_nx       = 8'd0;
          starve_nx    = 8'd0;
          mem_req_nx   = 1'b1;
          mem_we_nx    = 1'b0;
          mem_addr_nx  = {if_addr[31:2], 2'b00};
          mem_be_nx    = 4'b1111;
          mem_wdata_nx = 32'd0;
        end
      end
      BUSY_IF, BUSY_DM: begin
        if (mem_ack || tmo_inc == TMO_MAX) begin
          state_nx   = IDLE;
          mem_req_nx = 1'b0;
          if (state == BUSY_IF) begin
            if_ack_nx = 1'b1;
            if_err_nx = !mem_ack;
            if (mem_ack) if_rdata_nx = mem_rdata;
          end else begin
            dm_ack_nx = 1'b1;
            dm_err_nx = !mem_ack;
            if (mem_ack) dm_rdata_nx = mem_rdata;
          end
        end else begin
          tmo_nx = tmo_inc;
        end
      end
      default: begin
        state_nx   = IDLE;
        mem_req_nx = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tmo_cnt    <= 8'd0;
      starve_cnt <= 8'd0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
      if_ack     <= 1'b0;
      if_err     <= 1'b0;
      dm_ack     <= 1'b0;
      dm_err     <= 1'b0;
      if_rdata   <= 32'd0;
      dm_rdata   <= 32'd0;
    end else begin
      state      <= state_nx;
      tmo_cnt    <= tmo_nx;
      starve_cnt <= starve_nx;
      mem_req    <= mem_req_nx;
      mem_we     <= mem_we_nx;
      mem_addr   <= mem_addr_nx;
      mem_be     <= mem_be_nx;
      mem_wdata  <= mem_wdata_nx;
      if_ack     <= if_ack_nx;
      if_err     <= if_err_nx;
      dm_ack     <= dm_ack_nx;
      dm_err     <= dm_err_nx;
      if_rdata   <= if_rdata_nx;
      dm_rdata   <= dm_rdata_nx;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// fetch/data traffic checked against a transaction-level reference model.
`timescale 1ns/1ps
module tb_mem_port_arbiter;
  localparam int BURST = 4;
  localparam int TMO   = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, dm_req = 1'b0, dm_we = 1'b0;
  logic [31:0] if_addr = 32'd0, dm_addr = 32'd0, dm_wdata = 32'd0;
  logic [1:0]  dm_size = 2'd0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ack, if_err, dm_ack, dm_err, mem_req, mem_we, stall_if, stall_dm;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ack = 1'b0;

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t        if_txq[$];
  txn_t        dm_txq[$];
  txn_t        resp_t;
  bit          grant_log[$];
  int          req_cycles = 0, dm_during_if = 0, wcnt = 0, resp_wait = 0;
  bit          resp_en = 1'b1, force_ack = 1'b0, ovr_en = 1'b0, prev_req = 1'b0;
  logic [31:0] ovr_data = 32'd0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.MAX_DM_BURST(BURST), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ack(dm_ack), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_if(stall_if), .stall_dm(stall_dm)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [3:0] exp_be(input logic we, input logic [1:0] sz, input logic [31:0] a);
    if (!we || sz[1]) return 4'hF;
    if (sz == 2'd0) return 4'(1 << a[1:0]);
    return 4'(3 << (a[1:0] & 2'b10));
  endfunction

  function automatic logic [31:0] exp_lanes(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return 32'(d[7:0]) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(d[15:0]) * 32'h0001_0001;
    return d;
  endfunction

  function automatic bit exp_misaligned(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd1 && a[0]) || (sz >= 2'd2 && a[1:0] != 2'b00);
  endfunction

  // Memory model: logs each access at its first cycle and acks after resp_wait wait states.
  always @(posedge clk) begin
    #1;
    if (mem_req) begin
      if (!prev_req) begin
        wcnt   = 0;
        resp_t = '{mem_we, mem_addr, mem_be, mem_wdata};
        if (mem_addr[31]) begin
          dm_txq.push_back(resp_t);
          grant_log.push_back(1'b0);
          if (if_req) dm_during_if++;
        end else begin
          if_txq.push_back(resp_t);
          grant_log.push_back(1'b1);
        end
      end else begin
        wcnt++;
      end
      req_cycles++;
      mem_ack = force_ack || (resp_en && wcnt >= resp_wait);
    end else begin
      mem_ack = force_ack;
    end
    mem_rdata = ovr_en ? ovr_data : mem_word(mem_addr);
    prev_req  = mem_req;
  end

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if ({mem_req, mem_we, if_ack, if_err, dm_ack, dm_err} !== 6'b0) begin n_fails++; $display("[TB] FAIL reset_ctrl: got %b, expected 000000", {mem_req, mem_we, if_ack, if_err, dm_ack, dm_err}); end
    n_checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin n_fails++; $display("[TB] FAIL reset_mem: got addr %h wdata %h be %b, expected zeros", mem_addr, mem_wdata, mem_be); end
    n_checks++; if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin n_fails++; $display("[TB] FAIL reset_rdata: got %h/%h, expected 0/0", if_rdata, dm_rdata); end
    n_checks++; if ({stall_if, stall_dm} !== 2'b00) begin n_fails++; $display("[TB] FAIL reset_stall: got %b, expected 00", {stall_if, stall_dm}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fetch();
    int cyc;
    resp_wait = 0; ovr_en = 1'b1; ovr_data = 32'h00A0_0093;
    if_req = 1'b1; if_addr = 32'h100;
    #1;
    n_checks++; if (stall_if !== 1'b1 || mem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL fetch_c0: got stall %b req %b, expected 1 0", stall_if, mem_req); end
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0 || mem_be !== 4'hF) begin n_fails++; $display("[TB] FAIL fetch_c1: got req %b addr %h we %b be %b, expected 1 00000100 0 1111", mem_req, mem_addr, mem_we, mem_be); end
    n_checks++; if (stall_if !== 1'b1 || if_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL fetch_c1_stall: got stall %b ack %b, expected 1 0", stall_if, if_ack); end
    @(negedge clk);
    n_checks++; if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== 32'h00A0_0093) begin n_fails++; $display("[TB] FAIL fetch_c2: got ack %b err %b rdata %h, expected 1 0 00a00093", if_ack, if_err, if_rdata); end
    n_checks++; if (stall_if !== 1'b0 || mem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL fetch_c2_stall: got stall %b req %b, expected 0 0", stall_if, mem_req); end
    if_req = 1'b0; ovr_en = 1'b0;
    @(negedge clk);
    n_checks++; if (if_ack !== 1'b0) begin n_fails++; $display("[TB] FAIL fetch_pulse: got ack %b, expected 0", if_ack); end
    for (int k = 1; k <= 2; k++) begin
      resp_wait = k; if_req = 1'b1; if_addr = 32'h10E; cyc = 0;
      while (!if_ack && cyc < 20) begin @(negedge clk); cyc++; end
      n_checks++; if (cyc !== 2 + k) begin n_fails++; $display("[TB] FAIL fetch_wait%0d_latency: got %0d cycles, expected %0d", k, cyc, 2 + k); end
      n_checks++; if (if_rdata !== mem_word(32'h10C)) begin n_fails++; $display("[TB] FAIL fetch_wait%0d_rdata: got %h, expected %h", k, if_rdata, mem_word(32'h10C)); end
      if_req = 1'b0;
      @(negedge clk);
    end
    resp_wait = 0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] lanes;
  } st_vec_t;

  task automatic test_store();
    st_vec_t v[4];
    v[0] = '{1'b1, 2'd0, 32'h203, 32'h0000_0055, 4'b1000, 32'h5555_5555};
    v[1] = '{1'b1, 2'd1, 32'h202, 32'h0000_BEEF, 4'b1100, 32'hBEEF_BEEF};
    v[2] = '{1'b1, 2'd2, 32'h204, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D};
    v[3] = '{1'b0, 2'd0, 32'h201, 32'h0000_0011, 4'b1111, 32'h0};
    for (int i = 0; i < 4; i++) begin
      dm_req = 1'b1; dm_we = v[i].we; dm_size = v[i].sz; dm_addr = v[i].addr; dm_wdata = v[i].wdata;
      @(negedge clk);
      n_checks++; if (mem_req !== 1'b1 || mem_we !== v[i].we || mem_addr !== {v[i].addr[31:2], 2'b00} || mem_be !== v[i].be) begin n_fails++; $display("[TB] FAIL store%0d_req: got req %b we %b addr %h be %b, expected 1 %b %h %b", i, mem_req, mem_we, mem_addr, mem_be, v[i].we, {v[i].addr[31:2], 2'b00}, v[i].be); end
      if (v[i].we) begin
        n_checks++; if (mem_wdata !== v[i].lanes) begin n_fails++; $display("[TB] FAIL store%0d_wdata: got %h, expected %h", i, mem_wdata, v[i].lanes); end
      end
      @(negedge clk);
      n_checks++; if (dm_ack !== 1'b1 || dm_err !== 1'b0 || stall_dm !== 1'b0 || dm_rdata !== mem_word({v[i].addr[31:2], 2'b00})) begin n_fails++; $display("[TB] FAIL store%0d_ack: got ack %b err %b stall %b rdata %h, expected 1 0 0 %h", i, dm_ack, dm_err, stall_dm, dm_rdata, mem_word({v[i].addr[31:2], 2'b00})); end
      dm_req = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned();
    logic [1:0]  sz[3];
    logic [31:0] ad[3];
    int          rc0;
    sz[0] = 2'd2; ad[0] = 32'h1002;
    sz[1] = 2'd1; ad[1] = 32'h1001;
    sz[2] = 2'd3; ad[2] = 32'h1003;
    rc0 = req_cycles;
    for (int i = 0; i < 3; i++) begin
      dm_req = 1'b1; dm_we = 1'b0; dm_size = sz[i]; dm_addr = ad[i];
      #1;
      n_checks++; if (stall_dm !== 1'b1) begin n_fails++; $display("[TB] FAIL misal%0d_stall_c0: got %b, expected 1", i, stall_dm); end
      @(negedge clk);
      n_checks++; if (dm_ack !== 1'b1 || dm_err !== 1'b1 || mem_req !== 1'b0 || stall_dm !== 1'b0) begin n_fails++; $display("[TB] FAIL misal%0d_ack: got ack %b err %b req %b stall %b, expected 1 1 0 0", i, dm_ack, dm_err, mem_req, stall_dm); end
      dm_req = 1'b0;
      @(negedge clk);
      n_checks++; if (dm_ack !== 1'b0 || mem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL misal%0d_after: got ack %b req %b, expected 0 0", i, dm_ack, mem_req); end
    end
    n_checks++; if (req_cycles !== rc0) begin n_fails++; $display("[TB] FAIL misal_no_access: got %0d mem_req cycles, expected 0", req_cycles - rc0); end
  endtask

  task automatic test_contention();
    bit exp_order[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int first_ack = -1;
    int cyc = 0;
    rst = 1'b0; @(negedge clk); rst = 1'b1;
    grant_log.delete(); resp_wait = 0;
    if_req = 1'b1; if_addr = 32'h200;
    dm_req = 1'b1; dm_we = 1'b0; dm_size = 2'd2; dm_addr = 32'h8000_0100;
    while (grant_log.size() < 6 && cyc < 40) begin
      @(negedge clk); cyc++;
      if (first_ack < 0) begin
        if (if_ack) begin
          first_ack = grant_log.size();
          n_checks++; if (stall_if !== 1'b0) begin n_fails++; $display("[TB] FAIL contention_stall_ack: got %b, expected 0", stall_if); end
        end else begin
          n_checks++; if (stall_if !== 1'b1) begin n_fails++; $display("[TB] FAIL contention_stall_hold: got %b at cycle %0d, expected 1", stall_if, cyc); end
        end
      end
    end
    n_checks++; if (grant_log.size() < 6) begin n_fails++; $display("[TB] FAIL contention_budget: got %0d grants, expected 6", grant_log.size()); end
    for (int i = 0; i < 6 && i < grant_log.size(); i++) begin
      n_checks++; if (grant_log[i] !== exp_order[i]) begin n_fails++; $display("[TB] FAIL contention_order%0d: got %s, expected %s", i, grant_log[i] ? "IF" : "DM", exp_order[i] ? "IF" : "DM"); end
    end
    n_checks++; if (first_ack !== 5) begin n_fails++; $display("[TB] FAIL contention_if_release: got release after grant %0d, expected 5", first_ack); end
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_timeout();
    int rc0, cyc;
    resp_en = 1'b0; rc0 = req_cycles; cyc = 0;
    if_req = 1'b1; if_addr = 32'h300;
    while (!if_ack && cyc < 30) begin @(negedge clk); cyc++; end
    n_checks++; if (if_ack !== 1'b1 || if_err !== 1'b1) begin n_fails++; $display("[TB] FAIL timeout_ack: got ack %b err %b, expected 1 1", if_ack, if_err); end
    n_checks++; if (req_cycles - rc0 !== TMO) begin n_fails++; $display("[TB] FAIL timeout_req_len: got %0d, expected %0d", req_cycles - rc0, TMO); end
    n_checks++; if (cyc !== TMO + 1) begin n_fails++; $display("[TB] FAIL timeout_latency: got %0d, expected %0d", cyc, TMO + 1); end
    n_checks++; if (mem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL timeout_req_drop: got %b, expected 0", mem_req); end
    if_req = 1'b0;
    @(negedge clk);
    force_ack = 1'b1;
    repeat (2) @(negedge clk);
    force_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      n_checks++; if (if_ack !== 1'b0 || dm_ack !== 1'b0 || mem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL timeout_late_ack%0d: got if_ack %b dm_ack %b req %b, expected 0 0 0", i, if_ack, dm_ack, mem_req); end
    end
    resp_en = 1'b1; resp_wait = 0;
    if_req = 1'b1; if_addr = 32'h304;
    repeat (2) @(negedge clk);
    n_checks++; if (if_ack !== 1'b1 || if_err !== 1'b0 || if_rdata !== mem_word(32'h304)) begin n_fails++; $display("[TB] FAIL timeout_recover: got ack %b err %b rdata %h, expected 1 0 %h", if_ack, if_err, if_rdata, mem_word(32'h304)); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    resp_en = 1'b1; resp_wait = 3;
    dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'd0; dm_addr = 32'h8000_0041; dm_wdata = 32'h0000_00A7;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b0010 || mem_wdata !== 32'hA7A7_A7A7) begin n_fails++; $display("[TB] FAIL rstmid_req: got req %b we %b be %b wdata %h, expected 1 1 0010 a7a7a7a7", mem_req, mem_we, mem_be, mem_wdata); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; dm_req = 1'b0;
    n_checks++; if ({mem_req, mem_we, if_ack, if_err, dm_ack, dm_err} !== 6'b0) begin n_fails++; $display("[TB] FAIL rstmid_ctrl: got %b, expected 000000", {mem_req, mem_we, if_ack, if_err, dm_ack, dm_err}); end
    n_checks++; if (mem_addr !== 32'd0 || mem_wdata !== 32'd0 || mem_be !== 4'd0) begin n_fails++; $display("[TB] FAIL rstmid_mem: got addr %h wdata %h be %b, expected zeros", mem_addr, mem_wdata, mem_be); end
    n_checks++; if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin n_fails++; $display("[TB] FAIL rstmid_rdata: got %h/%h, expected 0/0", if_rdata, dm_rdata); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_checks++; if (dm_ack !== 1'b0 || mem_req !== 1'b0) begin n_fails++; $display("[TB] FAIL rstmid_quiet%0d: got ack %b req %b, expected 0 0", i, dm_ack, mem_req); end
      if (i == 1) force_ack = 1'b1;
      if (i == 2) force_ack = 1'b0;
    end
    resp_wait = 0;
    if_req = 1'b1; if_addr = 32'h400;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_we !== 1'b0) begin n_fails++; $display("[TB] FAIL rstmid_fresh_req: got req %b addr %h we %b, expected 1 00000400 0", mem_req, mem_addr, mem_we); end
    @(negedge clk);
    n_checks++; if (if_ack !== 1'b1 || if_rdata !== mem_word(32'h400)) begin n_fails++; $display("[TB] FAIL rstmid_fresh_ack: got ack %b rdata %h, expected 1 %h", if_ack, if_rdata, mem_word(32'h400)); end
    if_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    bit          if_pend = 1'b0, dm_pend = 1'b0, e_mis = 1'b0;
    int          if_age = 0, dm_age = 0;
    logic [31:0] e_if_addr = 32'd0, e_dm_addr = 32'd0, e_dm_wdata = 32'd0;
    logic [1:0]  e_sz = 2'd0;
    logic        e_we = 1'b0;
    txn_t        t;
    if_txq.delete(); dm_txq.delete();
    resp_en = 1'b1; force_ack = 1'b0; ovr_en = 1'b0;
    for (int cyc = 0; cyc < 640; cyc++) begin
      @(negedge clk);
      if (mem_req == 1'b0) resp_wait = $urandom_range(0, 3);
      if (if_ack) begin
        n_checks++;
        if (!if_pend) begin n_fails++; $display("[TB] FAIL rnd_if_spurious: got if_ack 1 with no request, expected 0"); end
        else if (if_err !== 1'b0 || if_txq.size() != 1) begin n_fails++; $display("[TB] FAIL rnd_if_txn: got err %b, %0d accesses, expected 0, 1", if_err, if_txq.size()); if_txq.delete(); end
        else begin
          t = if_txq.pop_front();
          if (t.addr !== e_if_addr || t.we !== 1'b0 || t.be !== 4'hF || if_rdata !== mem_word(e_if_addr) || dm_during_if > BURST) begin
            n_fails++; $display("[TB] FAIL rnd_if_data: got addr %h we %b be %b rdata %h dm_grants %0d, expected %h 0 1111 %h <=%0d", t.addr, t.we, t.be, if_rdata, dm_during_if, e_if_addr, mem_word(e_if_addr), BURST);
          end
        end
        if_pend = 1'b0;
      end
      if (dm_ack) begin
        n_checks++;
        if (!dm_pend) begin n_fails++; $display("[TB] FAIL rnd_dm_spurious: got dm_ack 1 with no request, expected 0"); end
        else if (e_mis) begin
          if (dm_err !== 1'b1 || dm_txq.size() != 0) begin n_fails++; $display("[TB] FAIL rnd_dm_misal: got err %b, %0d accesses, expected 1, 0", dm_err, dm_txq.size()); dm_txq.delete(); end
        end else if (dm_err !== 1'b0 || dm_txq.size() != 1) begin n_fails++; $display("[TB] FAIL rnd_dm_txn: got err %b, %0d accesses, expected 0, 1", dm_err, dm_txq.size()); dm_txq.delete(); end
        else begin
          t = dm_txq.pop_front();
          if (t.addr !== (e_dm_addr & 32'hFFFF_FFFC) || t.we !== e_we || t.be !== exp_be(e_we, e_sz, e_dm_addr) ||
              (e_we && t.wdata !== exp_lanes(e_sz, e_dm_wdata)) || dm_rdata !== mem_word(e_dm_addr & 32'hFFFF_FFFC)) begin
            n_fails++; $display("[TB] FAIL rnd_dm_data: got addr %h we %b be %b wdata %h rdata %h, expected %h %b %b %h %h", t.addr, t.we, t.be, t.wdata, dm_rdata, e_dm_addr & 32'hFFFF_FFFC, e_we, exp_be(e_we, e_sz, e_dm_addr), exp_lanes(e_sz, e_dm_wdata), mem_word(e_dm_addr & 32'hFFFF_FFFC));
          end
        end
        dm_pend = 1'b0;
      end
      if (if_pend && ++if_age > 60) begin n_checks++; n_fails++; $display("[TB] FAIL rnd_if_hang: got no if_ack in 60 cycles, expected one"); if_pend = 1'b0; end
      if (dm_pend && ++dm_age > 60) begin n_checks++; n_fails++; $display("[TB] FAIL rnd_dm_hang: got no dm_ack in 60 cycles, expected one"); dm_pend = 1'b0; end
      if (!if_pend) begin
        if (cyc < 600 && $urandom_range(0, 99) < 60) begin
          if_pend = 1'b1; if_age = 0; dm_during_if = 0;
          if_addr = {16'd0, 16'($urandom)}; e_if_addr = if_addr & 32'hFFFF_FFFC;
          if_req = 1'b1;
        end else if_req = 1'b0;
      end
      if (!dm_pend) begin
        if (cyc < 600 && $urandom_range(0, 99) < 70) begin
          dm_pend = 1'b1; dm_age = 0;
          e_sz = 2'($urandom_range(0, 3)); e_we = 1'($urandom_range(0, 1));
          e_dm_addr = $urandom | 32'h8000_0000; e_dm_wdata = $urandom;
          if ($urandom_range(0, 3) != 0)
            e_dm_addr = (e_sz == 2'd0) ? e_dm_addr : (e_sz == 2'd1) ? (e_dm_addr & 32'hFFFF_FFFE) : (e_dm_addr & 32'hFFFF_FFFC);
          e_mis = exp_misaligned(e_sz, e_dm_addr);
          dm_size = e_sz; dm_we = e_we; dm_addr = e_dm_addr; dm_wdata = e_dm_wdata;
          dm_req = 1'b1;
        end else dm_req = 1'b0;
      end
    end
    n_checks++; if (if_pend || dm_pend) begin n_fails++; $display("[TB] FAIL rnd_drain: got pending if %b dm %b, expected 0 0", if_pend, dm_pend); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_misaligned();
    test_contention();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no completion by 200us, expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single unified memory port between the IF stage (instruction fetch) and the MEM stage (loads/stores) of the pipelined RV32 core. It arbitrates with data-side priority and a bounded-starvation guarantee for fetch. It generates byte enables and write-data lanes for sub-word stores, detects misalignment, and times out a stuck memory. Its stall outputs feed the hazard unit alongside load-use stall logic, freezing PC/IF_ID while the port is busy.

## Interface

- MAX_DM_BURST, 4: consecutive DM grants allowed while if_req is pending before IF is forced.
- TIMEOUT, 255: BUSY cycles without mem_ack before abort (8-bit counter, 1..255).
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ack.
- if_addr  in  32  fetch byte address; [1:0] ignored.
- if_rdata  out  32  fetched word, valid while if_ack=1.
- if_ack  out  1  one-cycle completion pulse.
- if_err  out  1  with if_ack: access timed out.
- dm_req  in  1  data request; held with dm_* until dm_ack.
- dm_we  in  1  1=store, 0=load.
- dm_size  in  2  00 byte, 01 half, 10 word (funct3[1:0]); 11 treated as word.
- dm_addr  in  32  data byte address.
- dm_wdata  in  32  store data, right-aligned.
- dm_rdata  out  32  raw memory word, valid while dm_ack=1 (extension is done by the load unit).
- dm_ack  out  1  one-cycle completion pulse.
- dm_err  out  1  with dm_ack: misaligned or timed out.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  write strobe.
- mem_addr  out  32  word-aligned address ([1:0]=00).
- mem_be  out  4  byte enables (all 1 for reads).
- mem_wdata  out  32  lane-replicated write data.
- mem_rdata  in  32  read data, valid with mem_ack.
- mem_ack  in  1  memory completion, may arrive in first mem_req cycle.
- stall_if  out  1  if_req & ~if_ack (combinational).
- stall_dm  out  1  dm_req & ~dm_ack (combinational).

## Operation

- FSM states: IDLE, BUSY_IF, BUSY_DM.
- IDLE: evaluate requests each cycle.
  - dm_req only, or both with starve_cnt<MAX_DM_BURST: grant DM.
  - if_req only, or both with starve_cnt==MAX_DM_BURST: grant IF.
- Grant: register mem_addr/mem_we/mem_be/mem_wdata, go to BUSY_x, clear tmo_cnt.
- starve_cnt: +1 on a DM grant with if_req=1 (saturates at MAX_DM_BURST); cleared on an IF grant or a DM grant with if_req=0.
- Misaligned DM (half with addr[0]=1; word with addr[1:0]≠0): no memory access. Stay IDLE, pulse dm_ack+dm_err next cycle. Does not count as a grant.
- Byte: be=0001<<addr[1:0], wdata={4{wdata[7:0]}}. Half: be=0011<<{addr[1],0}, wdata={2{wdata[15:0]}}. Word: be=1111. Loads: be=1111, we=0.
- BUSY_x: mem_req=1, tmo_cnt+1 per cycle.
  - mem_ack=1: latch mem_rdata into x_rdata, pulse x_ack next cycle, return to IDLE.
  - tmo_cnt reaches TIMEOUT with no ack: drop mem_req, pulse x_ack+x_err, return to IDLE.
- mem_ack in IDLE is ignored.

## Timing

- Reset (rst=0 at an edge): state=IDLE; mem_req, mem_we, mem_be, mem_addr, mem_wdata, if_ack, dm_ack, if_err, dm_err, if_rdata, dm_rdata all 0; both counters 0. Applies mid-transaction: the transaction is abandoned, any later mem_ack is ignored.
- Zero-wait memory: request at cycle N, mem_req at N+1, mem_ack at N+1, x_ack at N+2. Throughput is one access per 2 cycles.
- mem_ack after k wait cycles: x_ack at N+2+k.
- Ack cycle: state is already IDLE. A req seen high in the ack cycle is a new request (back-to-back fetch), and arbitration applies normally.
- Misaligned: dm_req at N, dm_ack+dm_err at N+1, mem_req stays 0.
- Timeout: mem_req high for exactly TIMEOUT cycles, err ack on the following cycle.
- stall_x is high from request until the ack cycle inclusive-exclusive: low in the ack cycle.

## Test plan

- Zero-wait fetch: if_req, addr 0x100, mem_rdata 0x00A00093 acked immediately -> mem_addr 0x100 at cycle 1, if_ack with if_rdata 0x00A00093 at cycle 2, stall_if 1 for cycles 0–1.
- Store byte: dm_we=1, size 00, addr 0x203, wdata 0x55 -> mem_addr 0x200, be 1000, wdata 0x55555555. Store half at 0x202 -> be 1100.
- Contention/starvation: both request continuously, MAX_DM_BURST=4, zero-wait memory -> grant order DM,DM,DM,DM,IF,DM…; stall_if released only on the 5th grant's ack.
- Misaligned lw at 0x1002 -> dm_ack+dm_err next cycle, mem_req never asserted, stall_dm drops.
- Timeout: mem_ack tied 0, TIMEOUT=8 -> mem_req high 8 cycles then if_ack+if_err, state IDLE. A late mem_ack is ignored.
- Reset mid-BUSY_DM with 3 wait states: rst=0 for one edge -> all outputs 0 next cycle, no dm_ack. A later mem_ack is ignored, and a fresh if_req is granted normally.
